regfile_rdport_sched: RTL and testbench

//  Read-port sequencer for the 32x32 distributed-RAM register file (regfile_dp: async read, sync write).

---
 rtl/regfile_rdport_sched.sv | 146 ++++++++++++++
 tb/tb_regfile_rdport_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rdport_sched.sv
// Two-operand read sequencer for a single-read-port register file: time-multiplexes the
// read port over rs1/rs2 and forwards the write port with x0 suppression and bypass.
module regfile_rdport_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rs1_data,
  output logic [DATA_WIDTH-1:0] rsp_rs2_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_do,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_di
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   rs1_q;
  logic [ADDR_WIDTH-1:0]   rs2_q;
  logic [DATA_WIDTH-1:0]   rd_cur;
  logic                    same_idx;
  logic                    wr_hit1;
  logic                    wr_hit2;

  // Read value for index a: hardwired zero, then same-edge write bypass, then array contents.
  function automatic logic [DATA_WIDTH-1:0] rd_val(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [DATA_WIDTH-1:0] rdo
  );
    if (ZERO_REG && (a == {ADDR_WIDTH{1'b0}})) begin
      rd_val = {DATA_WIDTH{1'b0}};
    end else if (we && (wa == a)) begin
      rd_val = wd;
    end else begin
      rd_val = rdo;
    end
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rf_raddr  = (state == RD2) ? rs2_q : rs1_q;
  assign rf_waddr  = wr_addr;
  assign rf_di     = wr_data;
  assign rf_we     = wr_en && !rst && !(ZERO_REG && (wr_addr == {ADDR_WIDTH{1'b0}}));
  assign rd_cur    = rd_val(rf_raddr, wr_en, wr_addr, wr_data, rf_do);
  assign same_idx  = (rs1_q == rs2_q);
  // Keeps already-sampled operands coherent with writes landing after their read.
  assign wr_hit1   = rf_we && (wr_addr == rs1_q);
  assign wr_hit2   = rf_we && (wr_addr == rs2_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = RD1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD1: begin
        if (same_idx) begin
          state_nxt = RSP;
        end else begin
          state_nxt = RD2;
        end
      end
      RD2: state_nxt = RSP;
      RSP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RSP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rs1_q        <= {ADDR_WIDTH{1'b0}};
      rs2_q        <= {ADDR_WIDTH{1'b0}};
      rsp_rs1_data <= {DATA_WIDTH{1'b0}};
      rsp_rs2_data <= {DATA_WIDTH{1'b0}};
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
          end
        end
        RD1: begin
          rsp_rs1_data <= rd_cur;
          if (same_idx) begin
            rsp_rs2_data <= rd_cur;
          end
        end
        RD2: begin
          rsp_rs2_data <= rd_cur;
          if (wr_hit1) begin
            rsp_rs1_data <= wr_data;
          end
        end
        RSP: begin
          if (wr_hit1) begin
            rsp_rs1_data <= wr_data;
          end
          if (wr_hit2) begin
            rsp_rs2_data <= wr_data;
          end
        end
        default: begin
          rs1_q <= {ADDR_WIDTH{1'b0}};
          rs2_q <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_rdport_sched.sv
// Directed bench for regfile_rdport_sched with a behavioural async-read/sync-write array model.
module tb_regfile_rdport_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_do;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_di;

  int passed = 0;
  int total  = 0;

  // Array starts with a non-zero pattern so x0 must be forced to zero by the DUT.
  logic [31:0] mem [32] = '{default: 32'hBADC0DE0};

  regfile_rdport_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_raddr(rf_raddr), .rf_do(rf_do), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_di(rf_di)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_di;
  end
  assign rf_do = mem[rf_raddr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Presents a request for one edge; returns positioned just after the acceptance edge (RD1).
  task automatic issue(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_rs1_data !== 32'd0 || rsp_rs2_data !== 32'd0)
      $display("FAIL reset_data got %h/%h exp 0/0", rsp_rs1_data, rsp_rs2_data); else passed++;
    total++; if (rf_raddr !== 5'd0) $display("FAIL reset_raddr got %0d exp 0", rf_raddr); else passed++;
    step();
    rst = 1'b0;
    step();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
  endtask

  task automatic test_distinct();
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd9, 32'h12345678);
    issue(5'd5, 5'd9);
    total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL dist_rd1 got ready=%b valid=%b exp 0/0", req_ready, rsp_valid); else passed++;
    total++; if (rf_raddr !== 5'd5) $display("FAIL dist_raddr_rd1 got %0d exp 5", rf_raddr); else passed++;
    step();
    total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL dist_rd2 got ready=%b valid=%b exp 0/0", req_ready, rsp_valid); else passed++;
    total++; if (rf_raddr !== 5'd9) $display("FAIL dist_raddr_rd2 got %0d exp 9", rf_raddr); else passed++;
    step();
    total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL dist_rsp got valid=%b ready=%b exp 1/0", rsp_valid, req_ready); else passed++;
    total++; if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h12345678)
      $display("FAIL dist_data got %h/%h exp deadbeef/12345678", rsp_rs1_data, rsp_rs2_data); else passed++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL dist_release got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else passed++;
  endtask

  task automatic test_same_index();
    write_reg(5'd7, 32'hA5A5A5A5);
    issue(5'd7, 5'd7);
    total++; if (rsp_valid !== 1'b0) $display("FAIL same_rd1 got valid=%b exp 0", rsp_valid); else passed++;
    step();
    total++; if (rsp_valid !== 1'b1) $display("FAIL same_latency got valid=%b exp 1", rsp_valid); else passed++;
    total++; if (rsp_rs1_data !== 32'hA5A5A5A5 || rsp_rs2_data !== 32'hA5A5A5A5)
      $display("FAIL same_data got %h/%h exp a5a5a5a5/a5a5a5a5", rsp_rs1_data, rsp_rs2_data); else passed++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_zero_reg();
    write_reg(5'd3, 32'h33333333);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1;
    total++; if (rf_we !== 1'b0) $display("FAIL zero_rf_we got %b exp 0", rf_we); else passed++;
    wr_addr = 5'd3; wr_data = 32'h33333333;
    #1;
    total++; if (rf_we !== 1'b1) $display("FAIL nonzero_rf_we got %b exp 1", rf_we); else passed++;
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    step();
    wr_en = 1'b0;
    issue(5'd0, 5'd3);
    step();
    step();
    total++; if (rsp_valid !== 1'b1) $display("FAIL zero_valid got %b exp 1", rsp_valid); else passed++;
    total++; if (rsp_rs1_data !== 32'd0 || rsp_rs2_data !== 32'h33333333)
      $display("FAIL zero_data got %h/%h exp 0/33333333", rsp_rs1_data, rsp_rs2_data); else passed++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_bypass();
    issue(5'd4, 5'd9);
    write_reg(5'd4, 32'h11111111);
    step();
    total++; if (rsp_valid !== 1'b1) $display("FAIL byp_valid got %b exp 1", rsp_valid); else passed++;
    total++; if (rsp_rs1_data !== 32'h11111111 || rsp_rs2_data !== 32'h12345678)
      $display("FAIL byp_rd1 got %h/%h exp 11111111/12345678", rsp_rs1_data, rsp_rs2_data); else passed++;
    write_reg(5'd4, 32'h22222222);
    total++; if (rsp_rs1_data !== 32'h22222222 || rsp_valid !== 1'b1)
      $display("FAIL byp_rsp_rs1 got %h valid=%b exp 22222222/1", rsp_rs1_data, rsp_valid); else passed++;
    write_reg(5'd9, 32'h99999999);
    total++; if (rsp_rs2_data !== 32'h99999999 || rsp_rs1_data !== 32'h22222222)
      $display("FAIL byp_rsp_rs2 got %h/%h exp 22222222/99999999", rsp_rs1_data, rsp_rs2_data); else passed++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    issue(5'd5, 5'd9);
    step();
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h99999999) begin
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b %h/%h exp 1/0 deadbeef/99999999",
                 i, rsp_valid, req_ready, rsp_rs1_data, rsp_rs2_data);
        bad++;
      end else passed++;
      step();
    end
    // New request held high while releasing: must wait for the idle bubble.
    rsp_ready = 1'b1; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd9;
    step();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_bubble got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else passed++;
    step();
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_accept got ready=%b exp 0", req_ready); else passed++;
  endtask

  // Continues the request accepted at the end of test_backpressure and resets it in RD2.
  task automatic test_reset_midop();
    step();
    total++; if (rf_raddr !== 5'd9) $display("FAIL mid_in_rd2 got raddr=%0d exp 9", rf_raddr); else passed++;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666;
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mid_rst got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else passed++;
    total++; if (rsp_rs1_data !== 32'd0 || rsp_rs2_data !== 32'd0)
      $display("FAIL mid_rst_data got %h/%h exp 0/0", rsp_rs1_data, rsp_rs2_data); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL mid_rst_we got %b exp 0", rf_we); else passed++;
    step();
    wr_en = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL mid_no_rsp cycle %0d got valid=%b ready=%b exp 0/1", i, rsp_valid, req_ready);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_same_index();
    test_zero_reg();
    test_bypass();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
